// File: rtl/modulo_medidor_frequencia_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and default gate length.
package modulo_medidor_frequencia_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMeasure = 2'd1,
    StDone    = 2'd2
  } state_e;

  // 1 s window at a 50 MHz system clock
  localparam int unsigned GATE_CYCLES_DEFAULT = 50_000_000;

endpackage

// File: rtl/modulo_sincronizador_borda.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge detector.
module modulo_sincronizador_borda (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic edge_det
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= d;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign edge_det = r_sync2 & ~r_prev;

endmodule

// File: rtl/modulo_medidor_frequencia.sv
// Frequency meter: counts synchronized rising edges of sig_in over a GATE_CYCLES window
// and publishes the saturated count with a one-cycle valid strobe.
module modulo_medidor_frequencia
  import modulo_medidor_frequencia_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int unsigned GATE_W      = 26,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [CNT_W-1:0] freq_count,
  output logic             valid,
  output logic             overflow
);

  localparam logic [GATE_W-1:0] GateLast = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  state_e            r_state;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_ovf_flag;
  logic [CNT_W-1:0]  r_freq_count;
  logic              r_overflow;

  logic              w_edge;
  logic [CNT_W-1:0]  w_edge_next;
  logic              w_ovf_next;

  modulo_sincronizador_borda u_sincronizador (
    .clk      (clk),
    .clr      (clr),
    .d        (sig_in),
    .edge_det (w_edge)
  );

  // Saturating edge count; an increment attempted at the ceiling flags overflow instead.
  always_comb begin
    w_edge_next = r_edge_cnt;
    w_ovf_next  = r_ovf_flag;
    if (w_edge) begin
      if (r_edge_cnt == CntMax) begin
        w_ovf_next = 1'b1;
      end else begin
        w_edge_next = r_edge_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state      <= StIdle;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_ovf_flag   <= 1'b0;
      r_freq_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start || continuous) begin
            r_state    <= StMeasure;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
          end
        end
        StMeasure: begin
          r_gate_cnt <= r_gate_cnt + GATE_W'(1);
          r_edge_cnt <= w_edge_next;
          r_ovf_flag <= w_ovf_next;
          // The last gate cycle's edge is still included in the published count.
          if (r_gate_cnt == GateLast) begin
            r_freq_count <= w_edge_next;
            r_overflow   <= w_ovf_next;
            r_state      <= StDone;
          end
        end
        StDone: begin
          if (continuous) begin
            r_state    <= StMeasure;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
          end else begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy       = (r_state == StMeasure);
  assign valid      = (r_state == StDone);
  assign freq_count = r_freq_count;
  assign overflow   = r_overflow;

endmodule
